store_merger: RTL and testbench
===============================

Name: store_merger

Overview:
- Store-side counterpart of the load limiter.
- Takes sd/sw/sh/sb requests from the MEM stage and performs a read-modify-write on the 64-bit doubleword-addressed data memory.
- Inserts the stored width of rs2 at the correct byte lane.
- Sits between the datapath store path and the data memory port; full 64-bit stores bypass the read.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, memory word width; fixed at 64 (8 byte lanes).
- ACK_TIMEOUT, 16, max cycles waiting for mem_ack in any request state before abort.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  store request; sampled only in IDLE.
- st_type  in  2  00 sd, 01 sw, 10 sh, 11 sb.
- addr  in  ADDR_W  byte address.
- wdata  in  DATA_W  rs2 value; low bytes used per st_type.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.
- err_code  out  2  valid with done: 00 ok, 01 misaligned, 10 timeout.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  0 read, 1 write.
- mem_addr  out  ADDR_W  {addr[ADDR_W-1:3],3'b000}.
- mem_wdata  out  DATA_W  merged doubleword.
- mem_rdata  in  DATA_W  read data, valid with mem_ack when mem_we=0.
- mem_ack  in  1  memory accepts/completes the current request.

Behaviour:
- Reset (rst_n low at posedge): state IDLE. busy, done, mem_req, mem_we, err_code all 0; mem_addr, mem_wdata and internal buffers 0.
- Reset mid-operation aborts immediately: mem_req is 0 after that edge and no done pulse is produced.
- IDLE:
  - On start, latch st_type, addr and wdata.
  - Misaligned (see Optional Feature) -> RESP with err 01.
  - Else sd -> WR, with wbuf = wdata.
  - Else -> RD.
  - start outside IDLE is ignored.
- RD:
  - mem_req=1, mem_we=0.
  - On mem_ack: wbuf = merge(mem_rdata), then -> WR.
- WR:
  - mem_req=1, mem_we=1, mem_wdata=wbuf.
  - On mem_ack -> RESP with err 00.
- RESP: done=1 for exactly one cycle, err_code valid, then -> IDLE. busy is still 1 during RESP.
- Timeout:
  - A cycle counter clears on entering RD or WR and increments each cycle without ack.
  - When it reaches ACK_TIMEOUT-1 with no ack -> RESP with err 10; no write is issued.
  - An ack in the same cycle as the limit wins.
- Merge rules (lane offset from addr):
  - sw: lane word addr[2] receives wdata[31:0].
  - sh: halfword addr[2:1] receives wdata[15:0].
  - sb: byte addr[2:0] receives wdata[7:0].
  - All other bytes are kept from mem_rdata. Stored data is never extended.
- Latency with zero-wait memory (ack in first request cycle):
  - sd: done 2 cycles after start (IDLE->WR->RESP).
  - sw/sh/sb: 3 cycles.
  - Misaligned: 1 cycle.
- mem_addr is stable throughout RD and WR.

Optional Feature:
- Macro STORE_MERGER_MISALIGN_TRAP_EN.
- Defined:
  - sd with addr[2:0]!=0, sw with addr[1:0]!=0, or sh with addr[0]!=0 is misaligned: no memory access, RESP with err 01.
  - sb is never misaligned.
- Undefined:
  - The offending low bits are forced to zero (natural alignment) and the store proceeds normally.
  - err_code 01 is never produced.

Decomposition:
- Package store_merger_pkg holds:
  - enum st_type_e (ST_SD, ST_SW, ST_SH, ST_SB);
  - enum state_e (IDLE, RD, WR, RESP);
  - err codes ERR_OK, ERR_MISALIGN, ERR_TIMEOUT;
  - constant LANES=8.
- One natural sub-module: store_lane_merge, purely combinational (old word, wdata, st_type, offset) -> merged word. Reused by the FSM and directly unit-testable.

Test Plan:
- sb addr 0x1005 wdata 0xAB, mem 0x1122334455667788 -> read, then write 0x1122AB4455667788, done, err 00.
- sh addr 0x1002 wdata 0xFFFFBEEF, same mem -> write 0x11223344BEEF7788; mem_addr 0x1000 in both phases.
- sw addr 0x1004 wdata 0xDEADBEEF, same mem -> write 0xDEADBEEF55667788. sd addr 0x1000 wdata 0x0123456789ABCDEF -> no read request, write of the exact value, done 2 cycles after start.
- With STORE_MERGER_MISALIGN_TRAP_EN: sw at 0x1002 -> mem_req never asserted, done next cycle with err 01. Without the macro -> treated as 0x1000, lanes [31:0] written.
- ACK_TIMEOUT=4, mem_ack held 0 during an sb -> done with err 10 after 4 RD cycles, no write. A subsequent normal sb completes correctly.
- rst_n low during WR -> mem_req 0 next cycle, no done. start asserted while busy -> ignored, latched fields unchanged.

Source files
------------

// File: rtl/store_merger_pkg.sv
// Shared types and constants for the store merger and its lane-merge helper.
package store_merger_pkg;

   localparam int LANES = 8;

   typedef enum logic [1:0] {
      ST_SD = 2'b00,
      ST_SW = 2'b01,
      ST_SH = 2'b10,
      ST_SB = 2'b11
   } st_type_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RD   = 2'b01,
      WR   = 2'b10,
      RESP = 2'b11
   } state_e;

   localparam logic [1:0] ERR_OK       = 2'b00;
   localparam logic [1:0] ERR_MISALIGN = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

endpackage

// File: rtl/store_lane_merge.sv
// Combinational byte-lane merge: places the low bytes of wdata into the old
// doubleword at the naturally aligned lane selected by st_type and offset.
module store_lane_merge
   import store_merger_pkg::*;
(
   input  logic [LANES*8-1:0] old_word_i,
   input  logic [LANES*8-1:0] wdata_i,
   input  st_type_e           st_type_i,
   input  logic [2:0]         offset_i,
   output logic [LANES*8-1:0] merged_o
);

   logic [2:0]         base;
   logic [LANES-1:0]   laneMask;
   logic [LANES-1:0]   shiftedMask;
   logic [LANES*8-1:0] shiftedData;

   // Offset bits below the access size are dropped, giving natural alignment.
   always_comb begin
      base     = 3'd0;
      laneMask = 8'hFF;
      case (st_type_i)
         ST_SD: begin base = 3'd0;                   laneMask = 8'hFF; end
         ST_SW: begin base = {offset_i[2], 2'b00};   laneMask = 8'h0F; end
         ST_SH: begin base = {offset_i[2:1], 1'b0};  laneMask = 8'h03; end
         ST_SB: begin base = offset_i;               laneMask = 8'h01; end
         default: begin base = 3'd0;                 laneMask = 8'hFF; end
      endcase
      shiftedMask = laneMask << base;
      shiftedData = wdata_i << {base, 3'b000};
      merged_o    = old_word_i;
      for (int i = 0; i < LANES; i++) begin
         if (shiftedMask[i]) begin
            merged_o[i*8 +: 8] = shiftedData[i*8 +: 8];
         end
      end
   end

endmodule

// File: rtl/store_merger.sv
// Read-modify-write store path for sd/sw/sh/sb into a 64-bit doubleword memory.
// Define STORE_MERGER_MISALIGN_TRAP_EN to trap misaligned stores with err 01.
module store_merger
   import store_merger_pkg::*;
#(
   parameter int ADDR_W      = 64,
   parameter int DATA_W      = 64,
   parameter int ACK_TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [1:0]        st_type,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              busy,
   output logic              done,
   output logic [1:0]        err_code,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack
);

   localparam int CNT_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(ACK_TIMEOUT - 1);

   state_e            state_q;
   st_type_e          type_q;
   logic [2:0]        off_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] wbuf_q;
   logic [DATA_W-1:0] wbuf_d;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              busy_q;
   logic              done_q;
   logic              mem_req_q;
   logic              mem_we_q;
   logic [1:0]        err_q;
   logic              misalign;

`ifdef STORE_MERGER_MISALIGN_TRAP_EN
   always_comb begin
      misalign = 1'b0;
      case (st_type_e'(st_type))
         ST_SD:   misalign = |addr[2:0];
         ST_SW:   misalign = |addr[1:0];
         ST_SH:   misalign = addr[0];
         default: misalign = 1'b0;
      endcase
   end
`else
   assign misalign = 1'b0;
`endif

   store_lane_merge u_merge (
      .old_word_i (mem_rdata),
      .wdata_i    (wdata_q),
      .st_type_i  (type_q),
      .offset_i   (off_q),
      .merged_o   (wbuf_d)
   );

   // Every output is registered and changes together with the state it belongs to.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         type_q     <= ST_SD;
         off_q      <= 3'd0;
         wdata_q    <= '0;
         wbuf_q     <= '0;
         mem_addr_q <= '0;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         mem_req_q  <= 1'b0;
         mem_we_q   <= 1'b0;
         err_q      <= ERR_OK;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  type_q     <= st_type_e'(st_type);
                  off_q      <= addr[2:0];
                  wdata_q    <= wdata;
                  mem_addr_q <= {addr[ADDR_W-1:3], 3'b000};
                  cnt_q      <= '0;
                  busy_q     <= 1'b1;
                  if (misalign) begin
                     state_q <= RESP;
                     done_q  <= 1'b1;
                     err_q   <= ERR_MISALIGN;
                  end else if (st_type_e'(st_type) == ST_SD) begin
                     wbuf_q    <= wdata;
                     state_q   <= WR;
                     mem_req_q <= 1'b1;
                     mem_we_q  <= 1'b1;
                  end else begin
                     state_q   <= RD;
                     mem_req_q <= 1'b1;
                     mem_we_q  <= 1'b0;
                  end
               end
            end
            RD: begin
               if (mem_ack) begin
                  wbuf_q   <= wbuf_d;
                  state_q  <= WR;
                  mem_we_q <= 1'b1;
                  cnt_q    <= '0;
               end else if (cnt_q == CNT_LIMIT) begin
                  state_q   <= RESP;
                  mem_req_q <= 1'b0;
                  done_q    <= 1'b1;
                  err_q     <= ERR_TIMEOUT;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            WR: begin
               if (mem_ack) begin
                  state_q   <= RESP;
                  mem_req_q <= 1'b0;
                  mem_we_q  <= 1'b0;
                  done_q    <= 1'b1;
                  err_q     <= ERR_OK;
               end else if (cnt_q == CNT_LIMIT) begin
                  state_q   <= RESP;
                  mem_req_q <= 1'b0;
                  mem_we_q  <= 1'b0;
                  done_q    <= 1'b1;
                  err_q     <= ERR_TIMEOUT;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RESP: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               err_q   <= ERR_OK;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign err_code  = err_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = wbuf_q;

endmodule

// File: tb/tb_store_merger.sv
// Directed, table-driven bench for store_merger with a single-word memory model
// that acks immediately when enabled.
module tb_store_merger;
   import store_merger_pkg::*;

   localparam int ADDR_W      = 64;
   localparam int DATA_W      = 64;
   localparam int ACK_TIMEOUT = 4;
   localparam logic [63:0] MEM0 = 64'h1122334455667788;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic [1:0]        st_type;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              busy;
   logic              done;
   logic [1:0]        err_code;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   logic              ackEnable;
   logic [63:0]       memWord;

   int vecCount  = 0;
   int missCount = 0;

   typedef struct {
      string       name;
      logic [1:0]  stType;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [63:0] expData;
      int          expReads;
      int          expWrites;
      int          expLat;
      logic [1:0]  expErr;
   } vec_t;

   vec_t vecs[8];

   store_merger #(
      .ADDR_W      (ADDR_W),
      .DATA_W      (DATA_W),
      .ACK_TIMEOUT (ACK_TIMEOUT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .st_type   (st_type),
      .addr      (addr),
      .wdata     (wdata),
      .busy      (busy),
      .done      (done),
      .err_code  (err_code),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack)
   );

   always #5 clk = ~clk;

   assign mem_ack   = mem_req && ackEnable;
   assign mem_rdata = memWord;

   // Memory-side monitor, sampled mid-cycle so registered DUT outputs are settled.
   int          readAcks   = 0;
   int          writeAcks  = 0;
   int          rdReqCycles = 0;
   int          doneCount  = 0;
   logic [63:0] lastWrData = '0;
   logic [63:0] lastWrAddr = '0;
   logic [63:0] lastRdAddr = '0;

   always @(negedge clk) begin
      if (done) doneCount <= doneCount + 1;
      if (mem_req && !mem_we) rdReqCycles <= rdReqCycles + 1;
      if (mem_req && mem_ack) begin
         if (mem_we) begin
            writeAcks  <= writeAcks + 1;
            lastWrData <= mem_wdata;
            lastWrAddr <= mem_addr;
         end else begin
            readAcks   <= readAcks + 1;
            lastRdAddr <= mem_addr;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      vecCount++;
      if (act !== exp) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Drives one store request and waits (bounded) for done; lat counts edges from start.
   task automatic applyStimulus(input logic [1:0] t, input logic [63:0] a, input logic [63:0] d,
                                output int lat, output logic gotDone);
      @(negedge clk);
      start   = 1'b1;
      st_type = t;
      addr    = a;
      wdata   = d;
      lat     = 0;
      gotDone = 1'b0;
      do begin
         @(posedge clk);
         #1;
         lat++;
         if (lat == 1) start = 1'b0;
         gotDone = done;
      end while (!gotDone && lat < 40);
   endtask

   task automatic runVector(input vec_t v);
      int   lat;
      logic gotDone;
      int   r0;
      int   w0;
      memWord   = MEM0;
      ackEnable = 1'b1;
      r0 = readAcks;
      w0 = writeAcks;
      applyStimulus(v.stType, v.addr, v.wdata, lat, gotDone);
      checkOutput({v.name, " done"}, 64'(gotDone), 64'd1);
      checkOutput({v.name, " err"}, 64'(err_code), 64'(v.expErr));
      checkOutput({v.name, " latency"}, 64'(lat), 64'(v.expLat));
      @(posedge clk);
      #1;
      checkOutput({v.name, " done pulse width"}, 64'(done), 64'd0);
      checkOutput({v.name, " reads"}, 64'(readAcks - r0), 64'(v.expReads));
      checkOutput({v.name, " writes"}, 64'(writeAcks - w0), 64'(v.expWrites));
      if (v.expWrites > 0) begin
         checkOutput({v.name, " wdata"}, lastWrData, v.expData);
         checkOutput({v.name, " wr addr"}, lastWrAddr, {v.addr[63:3], 3'b000});
      end
      if (v.expReads > 0) begin
         checkOutput({v.name, " rd addr"}, lastRdAddr, {v.addr[63:3], 3'b000});
      end
   endtask

   initial begin
      int   lat;
      logic gotDone;
      int   r0;
      int   w0;
      int   q0;
      int   d0;

      vecs[0] = '{"sb", 2'b11, 64'h1005, 64'hAB, 64'h1122AB4455667788, 1, 1, 3, ERR_OK};
      vecs[1] = '{"sh", 2'b10, 64'h1002, 64'hFFFFBEEF, 64'h11223344BEEF7788, 1, 1, 3, ERR_OK};
      vecs[2] = '{"sw", 2'b01, 64'h1004, 64'hDEADBEEF, 64'hDEADBEEF55667788, 1, 1, 3, ERR_OK};
      vecs[3] = '{"sd", 2'b00, 64'h1000, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 0, 1, 2, ERR_OK};
      vecs[4] = '{"sb no extend", 2'b11, 64'h1000, 64'hFFFFFFFFFFFFFF5A, 64'h112233445566775A, 1, 1, 3, ERR_OK};
`ifdef STORE_MERGER_MISALIGN_TRAP_EN
      vecs[5] = '{"sw misaligned", 2'b01, 64'h1002, 64'hDEADBEEF, 64'h0, 0, 0, 1, ERR_MISALIGN};
      vecs[6] = '{"sh misaligned", 2'b10, 64'h1007, 64'h1234, 64'h0, 0, 0, 1, ERR_MISALIGN};
      vecs[7] = '{"sd misaligned", 2'b00, 64'h2003, 64'hCAFEF00D12345678, 64'h0, 0, 0, 1, ERR_MISALIGN};
`else
      vecs[5] = '{"sw misaligned", 2'b01, 64'h1002, 64'hDEADBEEF, 64'h11223344DEADBEEF, 1, 1, 3, ERR_OK};
      vecs[6] = '{"sh misaligned", 2'b10, 64'h1007, 64'h1234, 64'h1234334455667788, 1, 1, 3, ERR_OK};
      vecs[7] = '{"sd misaligned", 2'b00, 64'h2003, 64'hCAFEF00D12345678, 64'hCAFEF00D12345678, 0, 1, 2, ERR_OK};
`endif

      rst_n     = 1'b0;
      start     = 1'b0;
      st_type   = 2'b00;
      addr      = '0;
      wdata     = '0;
      ackEnable = 1'b0;
      memWord   = MEM0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset busy", 64'(busy), 64'd0);
      checkOutput("reset done", 64'(done), 64'd0);
      checkOutput("reset mem_req", 64'(mem_req), 64'd0);
      checkOutput("reset mem_we", 64'(mem_we), 64'd0);
      checkOutput("reset err_code", 64'(err_code), 64'd0);
      checkOutput("reset mem_addr", mem_addr, 64'd0);
      checkOutput("reset mem_wdata", mem_wdata, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         runVector(vecs[i]);
      end

      // Ack withheld during an sb read: expect four read cycles then a timeout.
      memWord   = MEM0;
      ackEnable = 1'b0;
      r0 = readAcks;
      w0 = writeAcks;
      q0 = rdReqCycles;
      applyStimulus(2'b11, 64'h1001, 64'h5C, lat, gotDone);
      checkOutput("timeout done", 64'(gotDone), 64'd1);
      checkOutput("timeout err", 64'(err_code), 64'(ERR_TIMEOUT));
      checkOutput("timeout latency", 64'(lat), 64'd5);
      @(posedge clk);
      #1;
      checkOutput("timeout rd cycles", 64'(rdReqCycles - q0), 64'd4);
      checkOutput("timeout writes", 64'(writeAcks - w0), 64'd0);
      checkOutput("timeout reads", 64'(readAcks - r0), 64'd0);
      checkOutput("timeout busy after", 64'(busy), 64'd0);
      runVector('{"sb after timeout", 2'b11, 64'h1001, 64'h5C, 64'h1122334455665C88, 1, 1, 3, ERR_OK});

      // Reset while WR is stalled: request drops at once and no done follows.
      ackEnable = 1'b0;
      d0 = doneCount;
      w0 = writeAcks;
      @(negedge clk);
      start   = 1'b1;
      st_type = 2'b00;
      addr    = 64'h3000;
      wdata   = 64'hAAAA5555AAAA5555;
      @(posedge clk);
      #1;
      start = 1'b0;
      checkOutput("pre-reset WR mem_req", 64'(mem_req), 64'd1);
      checkOutput("pre-reset WR mem_we", 64'(mem_we), 64'd1);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("mid-op reset mem_req", 64'(mem_req), 64'd0);
      checkOutput("mid-op reset busy", 64'(busy), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      checkOutput("mid-op reset no done", 64'(doneCount - d0), 64'd0);
      checkOutput("mid-op reset no write", 64'(writeAcks - w0), 64'd0);

      // A second start while busy must not disturb the latched request.
      memWord   = MEM0;
      ackEnable = 1'b0;
      w0 = writeAcks;
      @(negedge clk);
      start   = 1'b1;
      st_type = 2'b11;
      addr    = 64'h1003;
      wdata   = 64'h77;
      @(posedge clk);
      #1;
      st_type = 2'b01;
      addr    = 64'h4004;
      wdata   = 64'hDEADBEEF;
      @(negedge clk);
      start = 1'b0;
      ackEnable = 1'b1;
      lat = 0;
      gotDone = 1'b0;
      do begin
         @(posedge clk);
         #1;
         lat++;
         gotDone = done;
      end while (!gotDone && lat < 40);
      checkOutput("busy-start done", 64'(gotDone), 64'd1);
      checkOutput("busy-start err", 64'(err_code), 64'(ERR_OK));
      @(posedge clk);
      #1;
      checkOutput("busy-start writes", 64'(writeAcks - w0), 64'd1);
      checkOutput("busy-start wdata", lastWrData, 64'h1122334477667788);
      checkOutput("busy-start wr addr", lastWrAddr, 64'h1000);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
